// File: rtl/display_tempo_pkg.sv
// Shared definitions for the MM:SS 7-segment display path: limits,
// segment patterns, converter states and the BCD time bundle.
package display_tempo_pkg;

  localparam int unsigned MAX_SEC = 5999;

  // Segment patterns are gfedcba, active-low.
  localparam logic [6:0] SEG_DASH  = 7'b0111111;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_MIN,
    ST_TENS,
    ST_DONE
  } conv_state_e;

  typedef struct packed {
    logic [3:0] min_t;
    logic [3:0] min_u;
    logic [3:0] sec_t;
    logic [3:0] sec_u;
  } bcd_time_t;

  function automatic logic [6:0] seg_decode(input logic [3:0] digit);
    logic [6:0] pattern;
    case (digit)
      4'd0:    pattern = 7'b1000000;
      4'd1:    pattern = 7'b1111001;
      4'd2:    pattern = 7'b0100100;
      4'd3:    pattern = 7'b0110000;
      4'd4:    pattern = 7'b0011001;
      4'd5:    pattern = 7'b0010010;
      4'd6:    pattern = 7'b0000010;
      4'd7:    pattern = 7'b1111000;
      4'd8:    pattern = 7'b0000000;
      4'd9:    pattern = 7'b0010000;
      default: pattern = SEG_BLANK;
    endcase
    return pattern;
  endfunction

endpackage

// File: rtl/display_tempo_bin_mmss.sv
// Sequential binary-seconds to MM:SS BCD converter using repeated
// subtraction; emits a one-cycle valid pulse with a complete digit set.
module display_tempo_bin_mmss
  import display_tempo_pkg::*;
#(
  parameter int SEC_W = 13
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [SEC_W-1:0] segundos,
  output bcd_time_t        bcd,
  output logic             overflow,
  output logic             valid,
  output logic             captured_zero
);

  conv_state_e      state_q, state_d;
  logic [SEC_W-1:0] work_q, work_d;
  logic [SEC_W-1:0] latched_q, latched_d;
  logic [SEC_W-1:0] captured_q, captured_d;
  logic             cap_valid_q, cap_valid_d;
  logic [6:0]       min_q, min_d;
  logic [3:0]       min_t_q, min_t_d;
  logic [3:0]       sec_t_q, sec_t_d;
  logic             ovf_q, ovf_d;
  logic             min_small, sec_small;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    state_d     = state_q;
    work_d      = work_q;
    latched_d   = latched_q;
    captured_d  = captured_q;
    cap_valid_d = cap_valid_q;
    min_d       = min_q;
    min_t_d     = min_t_q;
    sec_t_d     = sec_t_q;
    ovf_d       = ovf_q;
    valid       = 1'b0;
    min_small   = (min_q < 7'd10);
    sec_small   = (work_q < SEC_W'(10));

    case (state_q)
      ST_IDLE: begin
        if (!cap_valid_q || (segundos != captured_q)) begin
          latched_d = segundos;
          work_d    = segundos;
          min_d     = 7'd0;
          min_t_d   = 4'd0;
          sec_t_d   = 4'd0;
          ovf_d     = (32'(segundos) > MAX_SEC);
          state_d   = (32'(segundos) > MAX_SEC) ? ST_DONE : ST_MIN;
        end
      end
      ST_MIN: begin
        if (work_q >= SEC_W'(60)) begin
          work_d = work_q - SEC_W'(60);
          min_d  = min_q + 7'd1;
        end else begin
          state_d = ST_TENS;
        end
      end
      ST_TENS: begin
        // Minutes and seconds are split concurrently; exit once both are single digits.
        if (!min_small) begin
          min_d   = min_q - 7'd10;
          min_t_d = min_t_q + 4'd1;
        end
        if (!sec_small) begin
          work_d  = work_q - SEC_W'(10);
          sec_t_d = sec_t_q + 4'd1;
        end
        if (min_small && sec_small) state_d = ST_DONE;
      end
      default: begin
        valid       = 1'b1;
        captured_d  = latched_q;
        cap_valid_d = 1'b1;
        state_d     = ST_IDLE;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk) begin
    // NOTE: the synchronous reset clears every register, including datapath, so an
    // interrupted conversion can never leak partial digits after reset.
    if (rst) begin
      state_q     <= ST_IDLE;
      work_q      <= '0;
      latched_q   <= '0;
      captured_q  <= '0;
      cap_valid_q <= 1'b0;
      min_q       <= '0;
      min_t_q     <= '0;
      sec_t_q     <= '0;
      ovf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      work_q      <= work_d;
      latched_q   <= latched_d;
      captured_q  <= captured_d;
      cap_valid_q <= cap_valid_d;
      min_q       <= min_d;
      min_t_q     <= min_t_d;
      sec_t_q     <= sec_t_d;
      ovf_q       <= ovf_d;
    end
  end

  assign bcd           = '{min_t: min_t_q, min_u: min_q[3:0], sec_t: sec_t_q, sec_u: work_q[3:0]};
  assign overflow      = ovf_q;
  assign captured_zero = cap_valid_q && (captured_q == '0);

endmodule

// File: rtl/display_tempo.sv
// MM:SS multiplexed 4-digit 7-segment driver: scan divider, blink timer,
// atomic display registers fed by the iterative BCD converter.
module display_tempo
  import display_tempo_pkg::*;
#(
  parameter int CLK_HZ   = 50_000_000,
  parameter int SCAN_HZ  = 1000,
  parameter int BLINK_HZ = 2,
  parameter int SEC_W    = 13
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [SEC_W-1:0] segundos,
  input  logic             sel,
  output logic [3:0]       an,
  output logic [6:0]       seg,
  output logic             dp,
  output logic             overflow
);

  localparam int SCAN_DIV  = CLK_HZ / (4 * SCAN_HZ);
  localparam int BLINK_DIV = CLK_HZ / BLINK_HZ;
  localparam int SCAN_W    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int BLINK_W   = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  logic [SCAN_W-1:0]  scan_cnt_q, scan_cnt_d;
  logic [BLINK_W-1:0] blink_cnt_q, blink_cnt_d;
  logic [1:0]         idx_q, idx_d;
  bcd_time_t          disp_q, disp_d;
  logic               disp_ovf_q, disp_ovf_d;
  logic [3:0]         an_q, an_d;
  logic [6:0]         seg_q, seg_d;
  logic               dp_q, dp_d;

  bcd_time_t conv_bcd;
  logic      conv_ovf, conv_valid, captured_zero;
  logic      blank;
  logic [3:0] digit;

  display_tempo_bin_mmss #(.SEC_W(SEC_W)) u_bin_mmss (
    .clk          (clk),
    .rst          (rst),
    .segundos     (segundos),
    .bcd          (conv_bcd),
    .overflow     (conv_ovf),
    .valid        (conv_valid),
    .captured_zero(captured_zero)
  );

  always_comb begin
    scan_cnt_d  = (scan_cnt_q == SCAN_W'(SCAN_DIV - 1)) ? '0 : scan_cnt_q + SCAN_W'(1);
    idx_d       = (scan_cnt_q == SCAN_W'(SCAN_DIV - 1)) ? idx_q - 2'd1 : idx_q;
    blink_cnt_d = (blink_cnt_q == BLINK_W'(BLINK_DIV - 1)) ? '0 : blink_cnt_q + BLINK_W'(1);
    disp_d      = conv_valid ? conv_bcd : disp_q;
    disp_ovf_d  = conv_valid ? conv_ovf : disp_ovf_q;

    case (idx_q)
      2'd3:    digit = disp_q.min_t;
      2'd2:    digit = disp_q.min_u;
      2'd1:    digit = disp_q.sec_t;
      default: digit = disp_q.sec_u;
    endcase

    // Expired timer: second half of each blink period is dark.
    blank = sel && captured_zero && (blink_cnt_q >= BLINK_W'(BLINK_DIV / 2));
    an_d  = blank ? 4'b1111 : ~(4'b0001 << idx_q);
    seg_d = blank ? SEG_BLANK : (disp_ovf_q ? SEG_DASH : seg_decode(digit));
    dp_d  = !((idx_q == 2'd2) && !blank);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      scan_cnt_q  <= '0;
      blink_cnt_q <= '0;
      idx_q       <= 2'd3;
      disp_q      <= '0;
      disp_ovf_q  <= 1'b0;
      an_q        <= 4'b1111;
      seg_q       <= SEG_BLANK;
      dp_q        <= 1'b1;
    end else begin
      scan_cnt_q  <= scan_cnt_d;
      blink_cnt_q <= blink_cnt_d;
      idx_q       <= idx_d;
      disp_q      <= disp_d;
      disp_ovf_q  <= disp_ovf_d;
      an_q        <= an_d;
      seg_q       <= seg_d;
      dp_q        <= dp_d;
    end
  end

  assign an       = an_q;
  assign seg      = seg_q;
  assign dp       = dp_q;
  assign overflow = disp_ovf_q;

endmodule

// File: tb/tb_display_tempo.sv
// Self-checking bench for display_tempo: cycle-level behavioural model of
// the displayed MM:SS value plus literal spot checks and random stimulus.
module tb_display_tempo;

  localparam int SEC_W = 13;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [SEC_W-1:0] segundos = '0;
  logic             sel = 1'b0;
  logic [3:0]       an;
  logic [6:0]       seg;
  logic             dp;
  logic             overflow;

  display_tempo #(
    .CLK_HZ  (1000),
    .SCAN_HZ (25),
    .BLINK_HZ(5),
    .SEC_W   (SEC_W)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .segundos(segundos),
    .sel     (sel),
    .an      (an),
    .seg     (seg),
    .dp      (dp),
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference segment patterns, gfedcba active-low, digits 0..9.
  logic [6:0] seg_tbl [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                               7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

  // Model state: k counts clock edges since reset released.
  int   k, done_edge, conv_val, captured, disp_val;
  bit   busy, valid, disp_ovf, model_ready;
  logic [3:0] exp_an;
  logic [6:0] exp_seg;
  logic       exp_dp, exp_ovf;

  task automatic model_step();
    int  idx, m, s, dig;
    bit  blank;
    if (rst) begin
      k = 0; busy = 0; valid = 0; captured = 0; disp_val = 0; disp_ovf = 0;
      exp_an = 4'hF; exp_seg = 7'h7F; exp_dp = 1'b1; exp_ovf = 1'b0;
      return;
    end
    k++;
    // Outputs for this edge come from the value shown before it.
    idx   = 3 - (((k - 1) / 10) % 4);
    blank = sel && valid && (captured == 0) && (((k - 1) % 200) >= 100);
    m = disp_val / 60;
    s = disp_val % 60;
    case (idx)
      3:       dig = m / 10;
      2:       dig = m % 10;
      1:       dig = s / 10;
      default: dig = s % 10;
    endcase
    exp_an  = blank ? 4'hF : ~(4'b0001 << idx);
    exp_seg = blank ? 7'h7F : (disp_ovf ? 7'b0111111 : seg_tbl[dig]);
    exp_dp  = !((idx == 2) && !blank);

    // Converter timing: IDLE, one MIN edge per minute plus exit, one TENS edge
    // per tens step plus exit, DONE; out-of-range values go straight to DONE.
    if (busy) begin
      if (k == done_edge) begin
        disp_val = conv_val;
        disp_ovf = (conv_val > 5999);
        captured = conv_val;
        valid    = 1;
        busy     = 0;
      end
    end else if (!valid || (int'(segundos) != captured)) begin
      conv_val = int'(segundos);
      busy     = 1;
      if (conv_val > 5999) done_edge = k + 1;
      else begin
        m = conv_val / 60;
        s = conv_val % 60;
        done_edge = k + m + (((m / 10) > (s / 10)) ? (m / 10) : (s / 10)) + 3;
      end
    end
    exp_ovf = disp_ovf;
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
    model_ready = 1;
  end

  initial forever begin
    @(negedge clk);
    if (model_ready) begin
      check("an", {28'd0, an}, {28'd0, exp_an});
      check("seg", {25'd0, seg}, {25'd0, exp_seg});
      check("dp", {31'd0, dp}, {31'd0, exp_dp});
      check("overflow", {31'd0, overflow}, {31'd0, exp_ovf});
    end
  end

  task automatic wait_an(input logic [3:0] target, input string name);
    int n = 0;
    while (an !== target && n < 100) begin
      @(negedge clk);
      n++;
    end
    check({name, "_an"}, {28'd0, an}, {28'd0, target});
  endtask

  task automatic count_dark(input int cycles, output int dark);
    dark = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (an == 4'b1111) dark++;
    end
  endtask

  initial begin
    int dark, hold;
    rst = 1'b1; segundos = '0; sel = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_an_lit", {28'd0, an}, 32'hF);
    check("reset_seg_lit", {25'd0, seg}, 32'h7F);
    check("reset_dp_lit", {31'd0, dp}, 32'd1);
    rst = 1'b0;

    @(negedge clk);
    check("first_slot_lit", {28'd0, an}, 32'h7);
    repeat (10) @(negedge clk);
    check("second_slot_lit", {28'd0, an}, 32'hB);
    check("colon_lit", {31'd0, dp}, 32'd0);
    check("zero_digit_lit", {25'd0, seg}, 32'h40);

    // 307 s -> 05:07
    segundos = 13'd307;
    repeat (130) @(negedge clk);
    wait_an(4'b1011, "v307");
    check("v307_five_lit", {25'd0, seg}, 32'b0010010);
    wait_an(4'b1110, "v307u");
    check("v307_seven_lit", {25'd0, seg}, 32'h78);

    // Expired timer blinks; stopwatch mode with same value does not.
    segundos = 13'd0; sel = 1'b1;
    repeat (130) @(negedge clk);
    count_dark(200, dark);
    check("blink_dark_lit", dark, 32'd100);
    sel = 1'b0;
    @(negedge clk);
    count_dark(200, dark);
    check("no_blink_lit", dark, 32'd0);

    // Boundary: 99:59 then overflow
    segundos = 13'd5999;
    repeat (130) @(negedge clk);
    wait_an(4'b0111, "v5999");
    check("v5999_nine_lit", {25'd0, seg}, 32'h10);
    check("v5999_ovf_lit", {31'd0, overflow}, 32'd0);
    segundos = 13'd6000;
    repeat (3) @(negedge clk);
    check("v6000_ovf_lit", {31'd0, overflow}, 32'd1);
    wait_an(4'b1011, "v6000");
    check("v6000_dash_lit", {25'd0, seg}, 32'b0111111);

    // Rapid changes during conversion: final value 102 -> 01:42
    segundos = 13'd100;
    @(negedge clk); segundos = 13'd101;
    @(negedge clk); segundos = 13'd102;
    repeat (250) @(negedge clk);
    wait_an(4'b1101, "v102");
    check("v102_four_lit", {25'd0, seg}, 32'h19);
    wait_an(4'b1110, "v102u");
    check("v102_two_lit", {25'd0, seg}, 32'h24);

    // Reset in the middle of the minute loop for 5940 -> 99:00 afterwards
    segundos = 13'd5940;
    repeat (20) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_an_lit", {28'd0, an}, 32'hF);
    check("midrst_seg_lit", {25'd0, seg}, 32'h7F);
    rst = 1'b0;
    repeat (130) @(negedge clk);
    wait_an(4'b0111, "v5940");
    check("v5940_nine_lit", {25'd0, seg}, 32'h10);
    wait_an(4'b1101, "v5940s");
    check("v5940_zero_lit", {25'd0, seg}, 32'h40);

    // Randomized traffic checked by the per-cycle model
    for (int it = 0; it < 60; it++) begin
      case ($urandom_range(0, 9))
        0, 1:    segundos = 13'd0;
        2:       segundos = SEC_W'($urandom_range(5990, 6010));
        3:       segundos = SEC_W'($urandom_range(6000, 8191));
        default: segundos = SEC_W'($urandom_range(0, 5999));
      endcase
      sel  = 1'($urandom_range(0, 1));
      hold = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : $urandom_range(20, 250);
      if ($urandom_range(0, 19) == 0) begin
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
      end
      repeat (hold) @(negedge clk);
    end
    repeat (300) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
